// File: rtl/ddp_token_sequencer.sv
// Round-robin arbiter that turns four button-event channels into {id, seq} tokens
// and delivers each over a 4-phase SEND/ACK handshake with a per-phase timeout.
module ddp_token_sequencer #(
    parameter int SEQ_W  = 6,
    parameter int TO_CYC = 3125000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       BEV,
    input  logic             EN,
    input  logic             CLR_ERR,
    input  logic             DDP_ACK,
    output logic             DDP_SEND,
    output logic [SEQ_W+1:0] DDP_DATA,
    output logic             BUSY,
    output logic             ERR,
    output logic [1:0]       LED
);

    localparam int CNT_W = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [3:0]       pend_reg;
    logic [SEQ_W-1:0] seq_reg;
    logic [1:0]       rr_ptr_reg;
    logic [CNT_W-1:0] to_cnt_reg;
    logic             ack_meta_reg;
    logic             ack_s;

    logic       grant_vld;
    logic [1:0] grant_id;
    logic       grant_fire;
    logic [3:0] grant_mask;

    // Scan downward so the last hit, i.e. the one closest to rr_ptr, wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (pend_reg[rr_ptr_reg + 2'(k)]) begin
                grant_vld = 1'b1;
                grant_id  = rr_ptr_reg + 2'(k);
            end
        end
    end

    // A stale ACK still seen from the previous token blocks any new grant.
    assign grant_fire = (state_reg == IDLE) && EN && grant_vld && !ack_s;
    assign grant_mask = grant_fire ? (4'b0001 << grant_id) : 4'b0000;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack_meta_reg <= 1'b0;
            ack_s        <= 1'b0;
        end else begin
            ack_meta_reg <= DDP_ACK;
            ack_s        <= ack_meta_reg;
        end
    end

    // New events are OR-ed in after the grant clear, so a same-cycle event re-arms the channel.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_reg <= 4'b0000;
        end else begin
            pend_reg <= (pend_reg & ~grant_mask) | BEV;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg  <= IDLE;
            DDP_SEND   <= 1'b0;
            DDP_DATA   <= '0;
            ERR        <= 1'b0;
            seq_reg    <= '0;
            rr_ptr_reg <= 2'd0;
            to_cnt_reg <= '0;
        end else begin
            // Clear first so a timeout set later in this block takes priority.
            if (CLR_ERR) begin
                ERR <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (grant_fire) begin
                        DDP_DATA   <= {grant_id, seq_reg};
                        DDP_SEND   <= 1'b1;
                        rr_ptr_reg <= grant_id + 2'd1;
                        to_cnt_reg <= '0;
                        state_reg  <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        DDP_SEND   <= 1'b0;
                        seq_reg    <= seq_reg + 1'b1;
                        to_cnt_reg <= '0;
                        state_reg  <= REL;
                    end else if (to_cnt_reg == TO_LAST) begin
                        DDP_SEND   <= 1'b0;
                        ERR        <= 1'b1;
                        to_cnt_reg <= '0;
                        state_reg  <= REL;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                REL: begin
                    if (!ack_s) begin
                        state_reg <= IDLE;
                    end else if (to_cnt_reg == TO_LAST) begin
                        ERR       <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    DDP_SEND  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign BUSY = (state_reg != IDLE);
    assign LED  = {BUSY, ERR};

endmodule

// File: tb/tb_ddp_token_sequencer.sv
// Scoreboard bench: stimulus pushes expected tokens, a negedge monitor pops and
// compares each token as DDP_SEND rises; handshake timing is checked inline.
module tb_ddp_token_sequencer;

    localparam int SEQ_W  = 6;
    localparam int TO_CYC = 16;

    logic             CLK = 1'b0;
    logic             RST;
    logic [3:0]       BEV;
    logic             EN;
    logic             CLR_ERR;
    logic             DDP_ACK;
    logic             DDP_SEND;
    logic [SEQ_W+1:0] DDP_DATA;
    logic             BUSY;
    logic             ERR;
    logic [1:0]       LED;

    ddp_token_sequencer #(.SEQ_W(SEQ_W), .TO_CYC(TO_CYC)) dut (
        .CLK(CLK), .RST(RST), .BEV(BEV), .EN(EN), .CLR_ERR(CLR_ERR),
        .DDP_ACK(DDP_ACK), .DDP_SEND(DDP_SEND), .DDP_DATA(DDP_DATA),
        .BUSY(BUSY), .ERR(ERR), .LED(LED)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [5:0] exp_seq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one line per delivered token, compared against the scoreboard queue.
    logic       send_prev = 1'b0;
    logic [7:0] held_data = 8'h00;
    always @(negedge CLK) begin
        if (DDP_SEND && !send_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_token", {24'h0, DDP_DATA}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                $display("token data=0x%02h expected=0x%02h", DDP_DATA, e);
                chk("token_data", {24'h0, DDP_DATA}, {24'h0, e});
            end
            held_data = DDP_DATA;
        end else if (DDP_SEND && send_prev) begin
            chk("data_stable", {24'h0, DDP_DATA}, {24'h0, held_data});
        end
        send_prev = DDP_SEND;
    end

    task automatic pulse(input logic [3:0] b);
        BEV = b;
        @(negedge CLK);
        BEV = 4'b0000;
    endtask

    task automatic push_tok(input logic [1:0] id, input logic [5:0] s);
        exp_q.push_back({id, s});
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        exp_seq = 6'd0;
    endtask

    // Waits for SEND, answers with ACK after dly cycles, checks SEND falls 3 edges later.
    task automatic do_hs(input int dly);
        int n;
        n = 0;
        while (!DDP_SEND && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (!DDP_SEND) begin
            chk("send_wait", 32'd0, 32'd1);
            return;
        end
        repeat (dly) @(negedge CLK);
        DDP_ACK = 1'b1;
        n = 0;
        while (DDP_SEND && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk("ack_to_send_fall", n, 32'd3);
        DDP_ACK = 1'b0;
        n = 0;
        while (BUSY && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk("busy_release", {31'h0, BUSY}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        BEV = 4'b0000; EN = 1'b1; CLR_ERR = 1'b0; DDP_ACK = 1'b0; RST = 1'b1;
        exp_seq = 6'd0;
        repeat (3) @(negedge CLK);
        chk("rst_send", {31'h0, DDP_SEND}, 32'd0);
        chk("rst_data", {24'h0, DDP_DATA}, 32'd0);
        chk("rst_busy", {31'h0, BUSY}, 32'd0);
        chk("rst_err", {31'h0, ERR}, 32'd0);
        chk("rst_led", {30'h0, LED}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Single event: SEND one cycle after pend.
        push_tok(2'd0, exp_seq); exp_seq++;
        pulse(4'b0001);
        chk("single_send_lat0", {31'h0, DDP_SEND}, 32'd0);
        @(negedge CLK);
        chk("single_send_lat1", {31'h0, DDP_SEND}, 32'd1);
        chk("single_busy", {31'h0, BUSY}, 32'd1);
        chk("single_led", {30'h0, LED}, 32'd2);
        do_hs(5);

        // Simultaneous events from a fresh reset: 0x00, 0x41, 0x82, 0xC3.
        do_reset();
        exp_q.push_back(8'h00); exp_q.push_back(8'h41);
        exp_q.push_back(8'h82); exp_q.push_back(8'hC3);
        exp_seq = 6'd4;
        pulse(4'b1111);
        for (int i = 0; i < 4; i++) do_hs(2);

        // Coalescing: three ch2 events during one ch0 handshake.
        push_tok(2'd0, 6'd4); push_tok(2'd2, 6'd5); exp_seq = 6'd6;
        pulse(4'b0001);
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            pulse(4'b0100);
            @(negedge CLK);
        end
        do_hs(1);
        do_hs(1);
        repeat (20) @(negedge CLK);
        chk("coalesce_idle_busy", {31'h0, BUSY}, 32'd0);
        chk("coalesce_queue", exp_q.size(), 32'd0);

        // Timeout with ACK held low: SEND high for TO_CYC cycles, ERR set.
        push_tok(2'd1, exp_seq);
        pulse(4'b0010);
        @(negedge CLK);
        cnt = 0;
        while (DDP_SEND && cnt < 40) begin
            cnt++;
            @(negedge CLK);
        end
        chk("timeout_send_cycles", cnt, TO_CYC);
        chk("timeout_err", {31'h0, ERR}, 32'd1);
        @(negedge CLK);
        chk("timeout_idle", {31'h0, BUSY}, 32'd0);
        chk("timeout_led", {30'h0, LED}, 32'd1);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;
        chk("clr_err", {31'h0, ERR}, 32'd0);

        // Sequence number unchanged by the timed-out token.
        push_tok(2'd3, exp_seq); exp_seq++;
        pulse(4'b1000);
        do_hs(3);

        // Gating: EN=0 holds a pending event.
        EN = 1'b0;
        pulse(4'b0001);
        repeat (10) @(negedge CLK);
        chk("gate_send", {31'h0, DDP_SEND}, 32'd0);
        chk("gate_busy", {31'h0, BUSY}, 32'd0);
        push_tok(2'd0, exp_seq); exp_seq++;
        EN = 1'b1;
        do_hs(1);

        // Stale ACK in IDLE blocks the grant until it drops.
        DDP_ACK = 1'b1;
        repeat (3) @(negedge CLK);
        pulse(4'b0010);
        repeat (8) @(negedge CLK);
        chk("stale_ack_send", {31'h0, DDP_SEND}, 32'd0);
        push_tok(2'd1, exp_seq); exp_seq++;
        DDP_ACK = 1'b0;
        do_hs(1);

        // Sequence wrap: run until seq returns to 0.
        for (int i = 0; i < 56; i++) begin
            push_tok(2'd0, exp_seq); exp_seq++;
            pulse(4'b0001);
            do_hs(1);
        end
        chk("wrap_seq_model", {26'h0, exp_seq}, 32'd1);

        // Async reset mid-REQ: outputs drop without a clock edge; token lost.
        push_tok(2'd2, exp_seq);
        pulse(4'b0100);
        @(negedge CLK);
        chk("pre_rst_send", {31'h0, DDP_SEND}, 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_send", {31'h0, DDP_SEND}, 32'd0);
        chk("async_rst_busy", {31'h0, BUSY}, 32'd0);
        chk("async_rst_led", {30'h0, LED}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        exp_seq = 6'd0;
        repeat (20) @(negedge CLK);
        chk("post_rst_quiet", {31'h0, DDP_SEND}, 32'd0);
        push_tok(2'd3, exp_seq); exp_seq++;
        pulse(4'b1000);
        do_hs(2);

        repeat (5) @(negedge CLK);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
